rr_stream_arbiter: RTL and testbench



---
 rtl/rr_stream_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_stream_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// Round-robin merge of NUM_CH valid/ready streams into one registered output.
// Each grant may carry up to MAX_BURST beats before priority rotates.
module rr_stream_arbiter #(
   parameter int NUM_CH    = 8,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int CH_W      = $clog2(NUM_CH)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_chan,
   input  logic                     out_ready,
   output logic                     busy
);
   localparam int BC_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [CH_W-1:0]   r_ptr;
   logic [CH_W-1:0]   r_grant;
   logic [BC_W-1:0]   r_burst_cnt;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [CH_W-1:0]   r_out_chan;

   logic              w_load_en;
   logic              w_any;
   logic [CH_W-1:0]   w_sel;
   logic              w_accept;
   logic [CH_W-1:0]   w_acc_ch;
   logic [BC_W-1:0]   w_cnt_nxt;

   assign w_load_en = !r_out_valid || out_ready;
   assign w_cnt_nxt = r_burst_cnt + BC_W'(1);

   // Walk downward so the lowest offset from r_ptr wins.
   always_comb begin
      logic [CH_W-1:0] v_idx;
      w_any = 1'b0;
      w_sel = '0;
      v_idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         v_idx = r_ptr + CH_W'(k);
         if (in_valid[v_idx]) begin
            w_any = 1'b1;
            w_sel = v_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_any && w_load_en && (MAX_BURST > 1)) w_next_state = BURST;
         end
         BURST: begin
            if (!in_valid[r_grant])
               w_next_state = IDLE;
            else if (w_accept && (w_cnt_nxt == BC_W'(MAX_BURST)))
               w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready = '0;
      w_acc_ch = r_grant;
      if (!reset) begin
         case (r_state)
            IDLE: begin
               w_acc_ch = w_sel;
               if (w_any && w_load_en) in_ready[w_sel] = 1'b1;
            end
            BURST: begin
               if (w_load_en && in_valid[r_grant]) in_ready[r_grant] = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign w_accept = |in_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr       <= '0;
         r_grant     <= '0;
         r_burst_cnt <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_acc_ch*DATA_W +: DATA_W];
            r_out_chan  <= w_acc_ch;
            if (r_state == IDLE) begin
               r_grant     <= w_sel;
               r_ptr       <= w_sel + CH_W'(1);
               r_burst_cnt <= BC_W'(1);
            end else begin
               r_burst_cnt <= w_cnt_nxt;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;
   assign busy      = (r_state == BURST) || r_out_valid;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed scoreboard bench for rr_stream_arbiter (NUM_CH=8, DATA_W=8, MAX_BURST=4).
// Sources send incrementing data per channel; expected beats are queued up front.
module tb_rr_stream_arbiter;
   localparam int NCH = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic [7:0]   in_valid;
   logic [63:0]  in_data;
   logic [7:0]   in_ready;
   logic         out_valid;
   logic [7:0]   out_data;
   logic [2:0]   out_chan;
   logic         out_ready;
   logic         busy;

   typedef struct packed {
      logic [2:0] ch;
      logic [7:0] d;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] seq [NCH];
   int         left [NCH];
   int         total = 0;
   int         bad = 0;
   logic       tog = 1'b0;
   logic       chk_ov = 1'b0;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_d;
   logic [2:0] prev_c;

   rr_stream_arbiter #(.NUM_CH(8), .DATA_W(8), .MAX_BURST(4)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clock = ~clock;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         in_data[i*8 +: 8] = seq[i];
         in_valid[i]       = (left[i] > 0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_burst(input int ch, input int base, input int n);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.ch = 3'(ch);
         b.d  = 8'(base + k);
         exp_q.push_back(b);
      end
   endtask

   task automatic set_src(input int ch, input int nbeats, input int base);
      left[ch] = nbeats;
      seq[ch]  = 8'(base);
   endtask

   task automatic clear_src();
      for (int i = 0; i < NCH; i++) begin
         left[i] = 0;
         seq[i]  = 8'(i * 16);
      end
   endtask

   // Called at negedge with inputs set; checks, then advances one clock.
   task automatic tick();
      logic [7:0] acc;
      beat_t      e;
      if (tog) out_ready = ~out_ready;
      #1;
      chk("rdy_onehot", 32'($countones(in_ready) <= 1), 32'd1);
      if (chk_ov) chk("ov_high", 32'(out_valid), 32'd1);
      if (prev_hold) begin
         chk("hold_data", 32'(out_data), 32'(prev_d));
         chk("hold_chan", 32'(out_chan), 32'(prev_c));
      end
      if (out_valid && out_ready) begin
         total++;
         assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL extra_beat observed=%0h expected=none", out_data);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_chan", 32'(out_chan), 32'(e.ch));
            chk("beat_data", 32'(out_data), 32'(e.d));
         end
      end
      prev_hold = out_valid && !out_ready;
      prev_d    = out_data;
      prev_c    = out_chan;
      acc       = in_valid & in_ready;
      @(posedge clock);
      @(negedge clock);
      for (int i = 0; i < NCH; i++) begin
         if (acc[i]) begin
            seq[i]  = seq[i] + 8'd1;
            left[i] = left[i] - 1;
         end
      end
   endtask

   task automatic run(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() > 0) begin
         chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      out_ready = 1'b0;
      tog       = 1'b0;
      chk_ov    = 1'b0;
      prev_hold = 1'b0;
      clear_src();
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      clear_src();
      out_ready = 1'b0;
      reset     = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_ov",    32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_chan",  32'(out_chan),  32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_ready", 32'(in_ready),  32'd0);
      @(negedge clock);

      // All channels requesting, full throughput, rotation 0..7 then wrap.
      for (int i = 0; i < NCH; i++) set_src(i, 100, i * 16);
      out_ready = 1'b1;
      for (int c = 0; c < NCH; c++) push_burst(c, c * 16, 4);
      push_burst(0, 4, 2);
      tick();
      chk_ov = 1'b1;
      run("all", 100);
      do_reset();

      // Single channel 5: repeated grants, in-order data.
      set_src(5, 100, 8'h10);
      out_ready = 1'b1;
      push_burst(5, 8'h10, 8);
      run("ch5", 100);
      do_reset();

      // Channels 2 and 6 with downstream stalling every other cycle.
      set_src(2, 100, 8'h20);
      set_src(6, 100, 8'h60);
      out_ready = 1'b0;
      tog       = 1'b1;
      push_burst(2, 8'h20, 4);
      push_burst(6, 8'h60, 4);
      run("toggle", 100);
      do_reset();

      // Channel 3 drops after 2 beats; channel 4 takes over, pointer lands at 5.
      set_src(3, 2, 8'h30);
      set_src(4, 4, 8'h40);
      out_ready = 1'b1;
      push_burst(3, 8'h30, 2);
      push_burst(4, 8'h40, 4);
      run("drop", 100);
      chk("drop_ptr", 32'(dut.r_ptr), 32'd5);
      do_reset();

      // Reset mid-burst with a beat held in the output register.
      set_src(1, 100, 8'h10);
      out_ready = 1'b1;
      push_burst(1, 8'h10, 2);
      run("midrst", 100);
      chk("midrst_ov_pre", 32'(out_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_rdy", 32'(in_ready), 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("midrst_ov", 32'(out_valid), 32'd0);
      for (int i = 0; i < NCH; i++) set_src(i, 100, i * 16);
      push_burst(0, 8'h00, 4);
      push_burst(1, 8'h10, 1);
      run("postrst", 100);
      do_reset();

      // Long downstream stall: exactly one held beat, no input accepted.
      for (int i = 0; i < NCH; i++) set_src(i, 100, i * 16);
      out_ready = 1'b1;
      push_burst(0, 8'h00, 2);
      run("prestall", 100);
      for (int k = 0; k < 10; k++) begin
         out_ready = 1'b0;
         #1;
         chk("stall_rdy",  32'(in_ready),  32'd0);
         chk("stall_ov",   32'(out_valid), 32'd1);
         chk("stall_data", 32'(out_data),  32'h02);
         chk("stall_busy", 32'(busy),      32'd1);
         tick();
      end
      out_ready = 1'b1;
      push_burst(0, 8'h02, 2);
      push_burst(1, 8'h10, 4);
      push_burst(2, 8'h20, 1);
      run("resume", 100);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
